memory_stage: RTL and testbench

Memory stage of the five-stage RISC-V pipeline. It consumes the execute-to-memory latch outputs and issues load/store requests to data memory over a req/ready handshake. It stalls the pipeline across wait states and drives the memory-to-writeback pipeline register: pc, halt, rd, writeback-source controls, alu_out and lane-aligned dload.

---
 rtl/common_types_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 35 +++
 rtl/memory_stage.sv | 171 +++++++++++++++++
 tb/tb_memory_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared pipeline types: word/register widths, memory-stage FSM states,
// access sizes (same encoding as the control unit's reg_wr_mem) and the MEM/WB latch layout.
package common_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        word_t       pc;
        logic        halt;
        reg_t        rd;
        logic [1:0]  reg_wr_src;
        logic [1:0]  reg_wr_mem;
        logic        reg_wr_mem_signed;
        word_t       alu_out;
        word_t       dload;
    } mwb_latch_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the core and a 32-bit data memory:
// store strobes/replicated write data, and right-justified load data.
module dmem_lane_align
    import common_types_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  offset,
    input  word_t       store_data,
    input  word_t       rdata,
    output logic [3:0]  strb,
    output word_t       wdata,
    output word_t       dload
);

    // Replicating the store data lets the strobes alone pick the lanes.
    always_comb begin
        case (size)
            BYTE: begin
                strb  = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            HALF: begin
                strb  = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    assign dload = rdata >> {offset, 3'b000};

endmodule

// File: rtl/memory_stage.sv
// RISC-V memory stage: data-memory req/ready handshake, stall generation and MEM/WB latch.
// Optional MEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into halts instead of bus cycles.
module memory_stage
    import common_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  word_t       ex_pc,
    input  word_t       ex_alu_out,
    input  word_t       ex_store_data,
    input  logic        ex_halt,
    input  reg_t        ex_rd,
    input  logic [1:0]  ex_reg_wr_src,
    input  logic [1:0]  ex_reg_wr_mem,
    input  logic        ex_reg_wr_mem_signed,
    input  logic        ex_dmem_rd,
    input  logic        ex_dmem_wr,
    output logic        dmem_req,
    output logic        dmem_wen,
    output word_t       dmem_addr,
    output word_t       dmem_wdata,
    output logic [3:0]  dmem_strb,
    input  logic        dmem_ready,
    input  word_t       dmem_rdata,
    input  logic        mwb_en,
    input  logic        mwb_flush,
    output logic        mem_stall,
    output word_t       mwb_pc,
    output logic        mwb_halt,
    output reg_t        mwb_rd,
    output logic [1:0]  mwb_reg_wr_src,
    output logic [1:0]  mwb_reg_wr_mem,
    output logic        mwb_reg_wr_mem_signed,
    output word_t       mwb_alu_out,
    output word_t       mwb_dload
);

    mem_state_t  state;
    word_t       req_addr;
    word_t       req_wdata;
    logic [3:0]  req_strb;
    logic        req_wen;
    logic        req_killed;
    mwb_latch_t  mwb_q;

    logic        access;
    logic        misaligned;
    logic        bus_access;
    logic        busy;
    logic        load_done;
    logic [1:0]  lane_off;
    logic [3:0]  ex_strb;
    word_t       ex_wdata;
    word_t       aligned_load;
    mem_size_t   ex_size;

    assign access  = ex_valid & (ex_dmem_rd | ex_dmem_wr);
    assign ex_size = mem_size_t'(ex_reg_wr_mem);
    assign busy    = (state == BUSY);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = access & (((ex_size == HALF) && (ex_alu_out[1:0] == 2'd3)) ||
                                  ((ex_size == WORD) && (ex_alu_out[1:0] != 2'd0)));
`else
    assign misaligned = 1'b0;
`endif

    assign bus_access = access & ~misaligned;

    // While waiting, read data must be shifted by the offset of the request in flight.
    assign lane_off = busy ? req_addr[1:0] : ex_alu_out[1:0];

    dmem_lane_align u_lane_align (
        .size       (ex_size),
        .offset     (lane_off),
        .store_data (ex_store_data),
        .rdata      (dmem_rdata),
        .strb       (ex_strb),
        .wdata      (ex_wdata),
        .dload      (aligned_load)
    );

    always_comb begin
        dmem_req   = 1'b0;
        dmem_wen   = 1'b0;
        mem_stall  = 1'b0;
        dmem_addr  = {ex_alu_out[31:2], 2'b00};
        dmem_wdata = ex_wdata;
        dmem_strb  = ex_strb;
        if (nRST && busy) begin
            dmem_req   = 1'b1;
            dmem_wen   = req_wen;
            dmem_addr  = {req_addr[31:2], 2'b00};
            dmem_wdata = req_wdata;
            dmem_strb  = req_strb;
            mem_stall  = ~dmem_ready;
        end else if (nRST && bus_access) begin
            dmem_req   = 1'b1;
            dmem_wen   = ex_dmem_wr;
            mem_stall  = ~dmem_ready;
        end
    end

    assign load_done = dmem_req & dmem_ready & ~dmem_wen;

    // req_killed remembers a flush that arrived while the transaction was still waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_strb   <= '0;
            req_wen    <= 1'b0;
            req_killed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_access && !dmem_ready) begin
                        state      <= BUSY;
                        req_addr   <= ex_alu_out;
                        req_wdata  <= ex_wdata;
                        req_strb   <= ex_strb;
                        req_wen    <= ex_dmem_wr;
                        req_killed <= mwb_flush;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        state      <= IDLE;
                        req_killed <= 1'b0;
                    end else if (mwb_flush) begin
                        req_killed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mwb_q <= '0;
        end else if (mwb_flush) begin
            mwb_q <= '0;
        end else if (mwb_en && !mem_stall) begin
            if (busy && req_killed) begin
                mwb_q <= '0;
            end else begin
                mwb_q.pc                <= ex_pc;
                mwb_q.halt              <= ex_halt | misaligned;
                mwb_q.rd                <= ex_rd;
                mwb_q.reg_wr_src        <= ex_reg_wr_src;
                mwb_q.reg_wr_mem        <= ex_reg_wr_mem;
                mwb_q.reg_wr_mem_signed <= ex_reg_wr_mem_signed;
                mwb_q.alu_out           <= ex_alu_out;
                mwb_q.dload             <= load_done ? aligned_load : '0;
            end
        end
    end

    assign mwb_pc                = mwb_q.pc;
    assign mwb_halt              = mwb_q.halt;
    assign mwb_rd                = mwb_q.rd;
    assign mwb_reg_wr_src        = mwb_q.reg_wr_src;
    assign mwb_reg_wr_mem        = mwb_q.reg_wr_mem;
    assign mwb_reg_wr_mem_signed = mwb_q.reg_wr_mem_signed;
    assign mwb_alu_out           = mwb_q.alu_out;
    assign mwb_dload             = mwb_q.dload;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level reference model.
module tb_memory_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_alu_out, ex_store_data;
    logic        ex_halt;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_reg_wr_src, ex_reg_wr_mem;
    logic        ex_reg_wr_mem_signed, ex_dmem_rd, ex_dmem_wr;
    logic        dmem_req, dmem_wen;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_strb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mwb_en, mwb_flush, mem_stall;
    logic [31:0] mwb_pc;
    logic        mwb_halt;
    logic [4:0]  mwb_rd;
    logic [1:0]  mwb_reg_wr_src, mwb_reg_wr_mem;
    logic        mwb_reg_wr_mem_signed;
    logic [31:0] mwb_alu_out, mwb_dload;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    memory_stage dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_halt(ex_halt), .ex_rd(ex_rd),
        .ex_reg_wr_src(ex_reg_wr_src), .ex_reg_wr_mem(ex_reg_wr_mem),
        .ex_reg_wr_mem_signed(ex_reg_wr_mem_signed),
        .ex_dmem_rd(ex_dmem_rd), .ex_dmem_wr(ex_dmem_wr),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_strb(dmem_strb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mwb_en(mwb_en), .mwb_flush(mwb_flush), .mem_stall(mem_stall),
        .mwb_pc(mwb_pc), .mwb_halt(mwb_halt), .mwb_rd(mwb_rd),
        .mwb_reg_wr_src(mwb_reg_wr_src), .mwb_reg_wr_mem(mwb_reg_wr_mem),
        .mwb_reg_wr_mem_signed(mwb_reg_wr_mem_signed),
        .mwb_alu_out(mwb_alu_out), .mwb_dload(mwb_dload)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_latch_zero(input string tag);
        chk({tag, ".pc"},   mwb_pc, 0);
        chk({tag, ".ctl"},  {mwb_halt, mwb_rd, mwb_reg_wr_src, mwb_reg_wr_mem, mwb_reg_wr_mem_signed}, 0);
        chk({tag, ".alu"},  mwb_alu_out, 0);
        chk({tag, ".load"}, mwb_dload, 0);
    endtask

    // One instruction through the stage: called at posedge+1, returns at posedge+1
    // after the edge that should have loaded the latch.
    task automatic run_txn(input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdat,
                           input logic halt, input logic [4:0] rd,
                           input logic [1:0] src, input logic [1:0] size, input logic sgn,
                           input logic valid, input logic rde, input logic wre,
                           input int nwait_in, input int flush_in);
        logic        access, mis, bus, killed, cleared;
        int          off, nwait, flush_k;
        logic [31:0] e_addr, e_strb, e_wdata, e_load;
        access  = valid && (rde || wre);
        off     = int'(addr % 4);
        mis     = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = access && ((size == 2'd1 && off == 3) || (size == 2'd2 && off != 0));
`endif
        bus     = access && !mis;
        nwait   = bus ? nwait_in : 0;
        flush_k = (flush_in > nwait) ? nwait : flush_in;
        e_addr  = addr - 32'(off);
        if (size == 2'd0)      e_strb = (32'd1 << off) % 16;
        else if (size == 2'd1) e_strb = (32'd3 << off) % 16;
        else                   e_strb = 32'd15;
        if (size == 2'd0)      e_wdata = (sdata % 256) * 32'h01010101;
        else if (size == 2'd1) e_wdata = (sdata % 65536) * 32'h00010001;
        else                   e_wdata = sdata;
        e_load  = (bus && !wre) ? (rdat >> (8 * off)) : 32'd0;
        killed  = 1'b0;

        ex_valid = valid; ex_pc = pc; ex_halt = halt; ex_rd = rd;
        ex_reg_wr_src = src; ex_reg_wr_mem = size; ex_reg_wr_mem_signed = sgn;
        ex_dmem_rd = rde; ex_dmem_wr = wre;
        for (int k = 0; k <= nwait; k++) begin
            if (k > 0 && k < nwait) begin
                ex_alu_out = $urandom; ex_store_data = $urandom;
            end else begin
                ex_alu_out = addr; ex_store_data = sdata;
            end
            dmem_ready = bus ? (k == nwait) : 1'($urandom % 2);
            dmem_rdata = (k == nwait) ? rdat : $urandom;
            mwb_flush  = (k == flush_k);
            if (mwb_flush) killed = 1'b1;
            #3;
            chk("req", dmem_req, bus);
            chk("stall", mem_stall, bus && (k < nwait));
            if (bus) begin
                chk("addr", dmem_addr, e_addr);
                chk("strb", dmem_strb, e_strb);
                chk("wdata", dmem_wdata, e_wdata);
                chk("wen", dmem_wen, wre);
            end
            @(posedge CLK); #1;
        end
        mwb_flush  = 1'b0;
        dmem_ready = 1'b0;
        cleared = killed;
        if (cleared) begin
            chk_latch_zero("flushed");
        end else begin
            chk("mwb_pc", mwb_pc, pc);
            chk("mwb_halt", mwb_halt, halt | mis);
            chk("mwb_rd", mwb_rd, rd);
            chk("mwb_src", mwb_reg_wr_src, src);
            chk("mwb_size", mwb_reg_wr_mem, size);
            chk("mwb_sgn", mwb_reg_wr_mem_signed, sgn);
            chk("mwb_alu", mwb_alu_out, addr);
            chk("mwb_dload", mwb_dload, e_load);
        end
    endtask

    initial begin
        nRST = 1'b0; mwb_en = 1'b1; mwb_flush = 1'b0;
        ex_valid = 1'b1; ex_dmem_rd = 1'b1; ex_dmem_wr = 1'b0;
        ex_pc = 32'h10; ex_alu_out = 32'h100; ex_store_data = 0; ex_halt = 0;
        ex_rd = 5'd1; ex_reg_wr_src = 0; ex_reg_wr_mem = 2; ex_reg_wr_mem_signed = 0;
        dmem_ready = 1'b0; dmem_rdata = 0;
        @(posedge CLK); @(posedge CLK); #4;
        chk("rst.req", dmem_req, 0);
        chk("rst.stall", mem_stall, 0);
        chk("rst.wen", dmem_wen, 0);
        chk_latch_zero("rst");
        @(posedge CLK); #1;
        nRST = 1'b1; ex_valid = 1'b0;

        // Directed: zero-wait load, byte store with waits, half load, flush while waiting.
        run_txn(32'h40, 32'h104, 32'h0, 32'hDEADBEEF, 0, 5'd5, 2'd1, 2'd2, 0, 1, 1, 0, 0, -1);
        run_txn(32'h44, 32'h203, 32'hA5, 32'h12345678, 0, 5'd0, 2'd0, 2'd0, 0, 1, 0, 1, 2, -1);
        run_txn(32'h48, 32'h102, 32'h0, 32'h80011234, 0, 5'd7, 2'd1, 2'd1, 1, 1, 1, 0, 1, -1);
        run_txn(32'h4C, 32'h108, 32'h0, 32'h55AA55AA, 0, 5'd9, 2'd1, 2'd2, 0, 1, 1, 0, 3, 1);
        run_txn(32'h50, 32'h102, 32'h0, 32'hCAFEF00D, 0, 5'd3, 2'd1, 2'd2, 0, 1, 1, 0, 1, -1);

        // Latch holds when mwb_en is low.
        run_txn(32'h1000, 32'h20, 32'h0, 32'h0, 0, 5'd4, 2'd0, 2'd2, 0, 1, 0, 0, 0, -1);
        mwb_en = 1'b0; ex_pc = 32'h2222; ex_rd = 5'd20;
        @(posedge CLK); #1;
        chk("hold.pc", mwb_pc, 32'h1000);
        chk("hold.rd", mwb_rd, 5'd4);
        mwb_en = 1'b1;

        // Reset while a transaction is waiting.
        ex_valid = 1'b1; ex_dmem_rd = 1'b1; ex_dmem_wr = 1'b0; ex_alu_out = 32'h300;
        ex_reg_wr_mem = 2'd2; dmem_ready = 1'b0;
        #3;
        chk("pre_rst.stall", mem_stall, 1);
        @(posedge CLK); #1;
        chk("busy.req", dmem_req, 1);
        nRST = 1'b0; #1;
        chk("arst.req", dmem_req, 0);
        chk("arst.stall", mem_stall, 0);
        chk_latch_zero("arst");
        @(posedge CLK); #1;
        nRST = 1'b1; ex_valid = 1'b0;
        #2;
        chk("post_rst.idle", dmem_req, 0);
        @(posedge CLK); #1;

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            int nw, fk;
            nw = int'($urandom_range(0, 3));
            fk = ($urandom % 6 == 0) ? int'($urandom_range(0, 3)) : -1;
            run_txn($urandom, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom),
                    2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom),
                    ($urandom % 8) != 0, 1'($urandom), 1'($urandom), nw, fk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
